crc_ahb_master: RTL and testbench
=================================

CRC_AHB_MASTER -- requirements
Module: crc_ahb_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, AHB base address of the CRC peripheral.
REQ-002 Parameter LEN_W, default 16, width of the job word count.
REQ-003 HCLK  in  1  single clock; all state on rising edge.
REQ-004 HRESETn  in  1  asynchronous, active-low reset.
REQ-005 HADDR  out  32  AHB address.
REQ-006 HTRANS  out  2  AHB transfer type; only IDLE (2'b00) and NON_SEQ (2'b10) are driven.
REQ-007 HWRITE  out  1  1 = write.
REQ-008 HSIZE  out  3  constant 3'b010 (word).
REQ-009 HWDATA  out  32  write data, data phase.
REQ-010 HRDATA  in  32  read data.
REQ-011 HREADY  in  1  transfer-complete / wait-state indicator.
REQ-012 HRESP  in  1  0 = OK, 1 = ERROR.
REQ-013 start  in  1  single-cycle job request; sampled only in IDLE.
REQ-014 len  in  LEN_W  number of data words; captured on start.
REQ-015 init_val, poly_val  in  32 each  values for CRC_INIT and CRC_POL; captured on start.
REQ-016 cr_val  in  8  CRC_CR value; captured on start.
REQ-017 din_data  in  32; din_valid  in  1; din_ready  out  1  data-word stream, transfer when valid && ready.
REQ-018 busy  out  1; done  out  1 (one-cycle pulse); error  out  1; result  out  32.

Function
REQ-019 Register offsets: CRC_DR 0x00, CRC_IDR 0x04, CRC_CR 0x08, CRC_INIT 0x10, CRC_POL 0x14, each added to BASE_ADDR.
REQ-020 States: IDLE, W_INIT, W_POL, W_CR, W_DR, R_DR, FIN.
REQ-021 IDLE with start=1: capture len/init_val/poly_val/cr_val, busy=1 next cycle, go to W_INIT; start outside IDLE is ignored.
REQ-022 Each transfer: address phase (HTRANS=NON_SEQ, HADDR, HWRITE) held until sampled with HREADY=1; then data phase with HTRANS=IDLE, held until HREADY=1; no overlap of transfers.
REQ-023 HWDATA is driven only during the write data phase and is held stable across wait states; otherwise 32'h0.
REQ-024 Sequence: write CRC_INIT=init_val, write CRC_POL=poly_val, write CRC_CR={24'h0, cr_val[7:1], 1'b1} (bit0 forces chain reset), then len writes to CRC_DR, then one read of CRC_DR.
REQ-025 In W_DR, address phase is issued only when din_valid=1; while din_valid=0, HTRANS=IDLE.
REQ-026 din_ready=1 for exactly the cycle in which a CRC_DR address phase is accepted (HREADY=1); din_data is latched that cycle and driven in the following data phase.
REQ-027 A down-counter of LEN_W bits tracks remaining words; decrement on each accepted DR address phase; no wrap below 0.
REQ-028 len=0: skip W_DR, go directly from W_CR to R_DR.
REQ-029 R_DR: capture HRDATA into result when the read data phase completes with HREADY=1 and HRESP=0; then FIN.
REQ-030 FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE; result held until next job completes.
REQ-031 HRESP=1 during any data phase: abandon job, no further transfers, result=32'h0, error=1, done pulse, return to IDLE.
REQ-032 error clears on the next accepted start.
REQ-033 Minimum job latency with zero wait states and din_valid always 1: 2*(len+4) cycles from start to done.

Reset
REQ-034 HRESETn=0 asynchronously forces: state IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, din_ready=0, busy=0, done=0, error=0, result=0, counter=0.
REQ-035 Reset mid-job aborts immediately; no transfer resumes after release; first start after release begins a fresh job.

Verification
REQ-036 len=2, init=FFFF_FFFF, poly=04C1_1DB7, cr=8'h00, data 0x1, 0x2, HREADY=1 -> writes to 0x10, 0x14, 0x08 (HWDATA 0x01), 0x00 twice, read 0x00; done at cycle 12; result=HRDATA.
REQ-037 Same job with HREADY=0 for 3 cycles in the first DR data phase -> HWDATA=0x1 held stable 4 cycles; done delayed by 3 cycles.
REQ-038 len=3, din_valid low 5 cycles before the 2nd word -> HTRANS=IDLE those cycles; exactly 3 DR writes; din_ready pulses 3 times.
REQ-039 len=0 -> CR write followed directly by CRC_DR read; done at cycle 8.
REQ-040 HRESP=1 on the CRC_POL write -> no CR/DR transfers, error=1, done pulse, result=0.
REQ-041 HRESETn low during 2nd DR write -> all outputs 0 asynchronously; after release, start runs full sequence from CRC_INIT.

Source files
------------

// File: rtl/crc_ahb_master.sv
// crc_ahb_master: AHB-Lite master that programs a memory-mapped CRC peripheral
// (INIT, POL, CR), streams a job's data words into CRC_DR and reads back the
// final CRC. Transfers never overlap: each address phase is followed by its
// data phase before the next address phase may begin.
module crc_ahb_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LEN_W     = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      init_val,
    input  logic [31:0]      poly_val,
    input  logic [7:0]       cr_val,
    input  logic [31:0]      din_data,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      result
);

    localparam logic [31:0] OFF_DR   = 32'h00;
    localparam logic [31:0] OFF_CR   = 32'h08;
    localparam logic [31:0] OFF_INIT = 32'h10;
    localparam logic [31:0] OFF_POL  = 32'h14;

    localparam logic [1:0] TRANS_IDLE    = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_INIT,
        S_W_POL,
        S_W_CR,
        S_W_DR,
        S_R_DR,
        S_FIN
    } state_t;

    state_t           state_reg, state_next;
    logic             data_ph_reg, data_ph_next;   // 0 = address phase, 1 = data phase
    logic [LEN_W-1:0] cnt_reg;
    logic [31:0]      init_reg, poly_reg, wdata_reg;
    logic [7:0]       cr_reg;
    logic [31:0]      result_reg;
    logic             error_reg;

    logic             xfer_state;
    logic             addr_req;
    logic             addr_ok;
    logic             data_err;
    logic [31:0]      reg_off;
    logic             reg_wr;

    // Decode the current transfer target and the bus handshake qualifiers.
    always_comb begin
        reg_off    = OFF_DR;
        reg_wr     = 1'b0;
        xfer_state = 1'b1;
        case (state_reg)
            S_W_INIT: begin reg_off = OFF_INIT; reg_wr = 1'b1; end
            S_W_POL:  begin reg_off = OFF_POL;  reg_wr = 1'b1; end
            S_W_CR:   begin reg_off = OFF_CR;   reg_wr = 1'b1; end
            S_W_DR:   begin reg_off = OFF_DR;   reg_wr = 1'b1; end
            S_R_DR:   begin reg_off = OFF_DR;   reg_wr = 1'b0; end
            default:  xfer_state = 1'b0;
        endcase
        // A CRC_DR write only starts once a data word is on offer.
        addr_req = xfer_state && !data_ph_reg && ((state_reg != S_W_DR) || din_valid);
        addr_ok  = addr_req && HREADY;
        data_err = data_ph_reg && HRESP;
    end

    // Bus-facing outputs derived from the registered sequencing state.
    always_comb begin
        HTRANS    = addr_req ? TRANS_NONSEQ : TRANS_IDLE;
        HADDR     = addr_req ? (BASE_ADDR + reg_off) : 32'h0;
        HWRITE    = addr_req && reg_wr;
        HSIZE     = 3'b010;
        HWDATA    = (data_ph_reg && reg_wr) ? wdata_reg : 32'h0;
        din_ready = addr_ok && (state_reg == S_W_DR);
        busy      = (state_reg != S_IDLE);
        done      = (state_reg == S_FIN);
        error     = error_reg;
        result    = result_reg;
    end

    // State and phase register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg   <= S_IDLE;
            data_ph_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            data_ph_reg <= data_ph_next;
        end
    end

    // Next-state logic: walk INIT -> POL -> CR -> DR* -> read DR -> FIN.
    always_comb begin
        state_next   = state_reg;
        data_ph_next = data_ph_reg;
        case (state_reg)
            S_IDLE: begin
                data_ph_next = 1'b0;
                if (start) state_next = S_W_INIT;
            end
            S_FIN: begin
                data_ph_next = 1'b0;
                state_next   = S_IDLE;
            end
            default: begin
                if (!data_ph_reg) begin
                    if (addr_ok) data_ph_next = 1'b1;
                end else if (HRESP) begin
                    // Error response: drop the job without further transfers.
                    data_ph_next = 1'b0;
                    state_next   = S_FIN;
                end else if (HREADY) begin
                    data_ph_next = 1'b0;
                    case (state_reg)
                        S_W_INIT: state_next = S_W_POL;
                        S_W_POL:  state_next = S_W_CR;
                        S_W_CR:   state_next = (cnt_reg == '0) ? S_R_DR : S_W_DR;
                        S_W_DR:   state_next = (cnt_reg == '0) ? S_R_DR : S_W_DR;
                        S_R_DR:   state_next = S_FIN;
                        default:  state_next = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Job parameters, word counter, write-data latch, result and error flag.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_reg    <= '0;
            init_reg   <= 32'h0;
            poly_reg   <= 32'h0;
            cr_reg     <= 8'h0;
            wdata_reg  <= 32'h0;
            result_reg <= 32'h0;
            error_reg  <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && start) begin
                cnt_reg   <= len;
                init_reg  <= init_val;
                poly_reg  <= poly_val;
                cr_reg    <= cr_val;
                error_reg <= 1'b0;
            end
            if (addr_ok) begin
                case (state_reg)
                    S_W_INIT: wdata_reg <= init_reg;
                    S_W_POL:  wdata_reg <= poly_reg;
                    // Bit 0 of CR is forced so the peripheral restarts its chain.
                    S_W_CR:   wdata_reg <= {24'h0, cr_reg | 8'h01};
                    S_W_DR:   wdata_reg <= din_data;
                    default:  wdata_reg <= 32'h0;
                endcase
                if (state_reg == S_W_DR && cnt_reg != '0)
                    cnt_reg <= cnt_reg - LEN_W'(1);
            end
            if (data_err) begin
                result_reg <= 32'h0;
                error_reg  <= 1'b1;
            end else if (state_reg == S_R_DR && data_ph_reg && HREADY) begin
                result_reg <= HRDATA;
            end
        end
    end

endmodule

// File: tb/tb_crc_ahb_master.sv
// tb_crc_ahb_master: directed and randomized jobs against an AHB slave / data
// source agent; each job's observed bus transfers are compared to the list of
// transfers the job should produce.
module tb_crc_ahb_master;

    localparam logic [31:0] BASE = 32'h4002_3000;
    localparam int LW = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] HADDR, HWDATA, HRDATA = 32'h0, result;
    logic [1:0]  HTRANS;
    logic        HWRITE, din_ready, busy, done, error;
    logic [2:0]  HSIZE;
    logic        HREADY = 1'b1, HRESP = 1'b0, start = 1'b0, din_valid = 1'b0;
    logic [LW-1:0] len = '0;
    logic [31:0] init_val = 32'h0, poly_val = 32'h0, din_data = 32'h0;
    logic [7:0]  cr_val = 8'h0;

    crc_ahb_master #(.BASE_ADDR(BASE), .LEN_W(LW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .start(start), .len(len),
        .init_val(init_val), .poly_val(poly_val), .cr_val(cr_val),
        .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
        .busy(busy), .done(done), .error(error), .result(result)
    );

    always #5 HCLK = ~HCLK;

    int compares = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        int          dcyc;
    } xfer_t;

    xfer_t       rec_q[$];
    xfer_t       exp_q[$];
    logic [31:0] words[$];

    int cyc = 0;
    always @(posedge HCLK) cyc++;

    // Agent knobs and observations.
    bit          rand_wait = 0, rand_valid = 0, err_en = 0, gap_first = 0;
    int          stall_pending = 0;
    logic [31:0] err_addr = 32'h0, rd_val = 32'h0;
    int          widx = 0, dready_cnt = 0, done_cnt = 0, done_cyc = 0, proto_err = 0;

    // Agent private state.
    bit          in_data = 0, valid_hold = 0, exp_rdy;
    logic [31:0] cur_addr, cur_wdata;
    bit          cur_wr;
    int          dcyc = 0, stall_cnt = 0, gap_cnt = 0;

    // AHB slave + data source: drive inputs on the falling edge, then sample
    // the resulting DUT outputs 1 time unit later.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            in_data = 0; valid_hold = 0; gap_cnt = 0; stall_cnt = 0;
            HREADY = 1; HRESP = 0; din_valid = 0;
        end else begin
            if (in_data && stall_cnt > 0) begin HREADY = 0; stall_cnt--; end
            else if (rand_wait && $urandom_range(0, 3) == 0) HREADY = 0;
            else HREADY = 1;
            HRESP = in_data && err_en && (cur_addr == err_addr);
            if (HRESP) HREADY = 1;
            HRDATA = rd_val;
            if (valid_hold) din_valid = 1;
            else if (gap_cnt > 0) begin din_valid = 0; gap_cnt--; end
            else if (widx >= words.size()) din_valid = 0;
            else if (rand_valid) din_valid = 1'($urandom_range(0, 1));
            else din_valid = 1;
            din_data = (widx < words.size()) ? words[widx] : $urandom;
            #1;
            if (HTRANS != 2'b00 && HTRANS != 2'b10) proto_err++;
            exp_rdy = !in_data && HTRANS == 2'b10 && HWRITE && HADDR == BASE && HREADY && din_valid;
            if (!in_data) begin
                if (HWDATA !== 32'h0) proto_err++;
                if (HTRANS == 2'b10) begin
                    if (HSIZE !== 3'b010) proto_err++;
                    if (HADDR == BASE && HWRITE && !din_valid) proto_err++;
                    if (HREADY) begin
                        in_data = 1; cur_addr = HADDR; cur_wr = HWRITE; dcyc = 0;
                        if (HADDR == BASE && HWRITE && stall_pending > 0) begin
                            stall_cnt = stall_pending; stall_pending = 0;
                        end
                    end
                end
            end else begin
                if (HTRANS !== 2'b00) proto_err++;
                dcyc++;
                if (cur_wr) begin
                    if (dcyc == 1) cur_wdata = HWDATA;
                    else if (HWDATA !== cur_wdata) proto_err++;
                end else if (HWDATA !== 32'h0) proto_err++;
                if (HREADY) begin
                    rec_q.push_back('{cur_addr, cur_wr, cur_wr ? cur_wdata : HRDATA, dcyc});
                    in_data = 0;
                end
            end
            if (din_ready !== exp_rdy) proto_err++;
            if (din_ready && din_valid) begin
                dready_cnt++; widx++;
                if (gap_first && widx == 1) gap_cnt = 5;
            end
            valid_hold = din_valid && !din_ready;
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic prep(input int n, input bit seq_words, input logic [31:0] iv,
                        input logic [31:0] pv, input logic [7:0] cv, input bit err_pol);
        words.delete(); rec_q.delete(); exp_q.delete();
        for (int i = 0; i < n; i++) words.push_back(seq_words ? 32'(i + 1) : $urandom);
        widx = 0; dready_cnt = 0; done_cnt = 0; proto_err = 0;
        rd_val = $urandom; err_en = err_pol; err_addr = BASE + 32'h14;
        exp_q.push_back('{BASE + 32'h10, 1'b1, iv, 0});
        exp_q.push_back('{BASE + 32'h14, 1'b1, pv, 0});
        if (!err_pol) begin
            exp_q.push_back('{BASE + 32'h08, 1'b1, {24'h0, cv} | 32'h1, 0});
            for (int i = 0; i < n; i++) exp_q.push_back('{BASE, 1'b1, words[i], 0});
            exp_q.push_back('{BASE, 1'b0, rd_val, 0});
        end
    endtask

    task automatic pulse_start(input int n, input logic [31:0] iv, input logic [31:0] pv,
                               input logic [7:0] cv, output int st);
        @(negedge HCLK);
        start = 1; len = LW'(n); init_val = iv; poly_val = pv; cr_val = cv; st = cyc;
        @(negedge HCLK);
        start = 0; len = LW'($urandom); init_val = $urandom; poly_val = $urandom; cr_val = 8'($urandom);
    endtask

    task automatic run_job(input string name, input int n, input bit seq_words,
                           input logic [31:0] iv, input logic [31:0] pv, input logic [7:0] cv,
                           input int exp_lat, input bit err_pol, input bit poke, input int stall);
        int st, t, m;
        prep(n, seq_words, iv, pv, cv, err_pol);
        stall_pending = stall;
        pulse_start(n, iv, pv, cv, st);
        check({name, ".busy"}, 32'(busy), 32'h1);
        check({name, ".err_clr"}, 32'(error), 32'h0);
        if (poke) begin
            repeat (3) @(negedge HCLK);
            start = 1; len = 7;
            @(negedge HCLK);
            start = 0;
        end
        t = 0;
        while (done_cnt == 0 && t < 3000) begin @(negedge HCLK); #2; t++; end
        check({name, ".done_seen"}, 32'(done_cnt), 32'h1);
        if (exp_lat >= 0) check({name, ".latency"}, 32'(done_cyc - st - 1), 32'(exp_lat));
        check({name, ".result"}, result, err_pol ? 32'h0 : rd_val);
        check({name, ".error"}, 32'(error), 32'(err_pol));
        @(negedge HCLK); #2;
        check({name, ".done_pulse"}, 32'(done_cnt), 32'h1);
        check({name, ".busy_off"}, 32'(busy), 32'h0);
        check({name, ".result_hold"}, result, err_pol ? 32'h0 : rd_val);
        check({name, ".error_hold"}, 32'(error), 32'(err_pol));
        check({name, ".n_xfer"}, 32'(rec_q.size()), 32'(exp_q.size()));
        m = (rec_q.size() < exp_q.size()) ? rec_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s.x%0d.addr", name, i), rec_q[i].addr, exp_q[i].addr);
            check($sformatf("%s.x%0d.wr", name, i), 32'(rec_q[i].wr), 32'(exp_q[i].wr));
            check($sformatf("%s.x%0d.data", name, i), rec_q[i].data, exp_q[i].data);
        end
        if (stall > 0 && m > 3) check({name, ".stall_cycles"}, 32'(rec_q[3].dcyc), 32'(stall + 1));
        check({name, ".protocol"}, 32'(proto_err), 32'h0);
        check({name, ".din_ready_cnt"}, 32'(dready_cnt), err_pol ? 32'h0 : 32'(n));
        $display("job %s len=%0d xfers=%0d result=0x%08h error=%0b", name, n, rec_q.size(), result, error);
    endtask

    initial begin
        int t, busy_seen;
        // Reset state.
        repeat (3) @(negedge HCLK);
        #2;
        check("rst.htrans", 32'(HTRANS), 32'h0);
        check("rst.haddr", HADDR, 32'h0);
        check("rst.busy_done_err", {29'h0, busy, done, error}, 32'h0);
        check("rst.result", result, 32'h0);
        @(negedge HCLK);
        HRESETn = 1;
        @(negedge HCLK); #2;
        check("idle.htrans", 32'(HTRANS), 32'h0);

        run_job("basic", 2, 1, 32'hFFFF_FFFF, 32'h04C1_1DB7, 8'h00, 12, 0, 0, 0);
        run_job("stall", 2, 1, 32'hFFFF_FFFF, 32'h04C1_1DB7, 8'h00, 15, 0, 0, 3);
        gap_first = 1;
        run_job("gap", 3, 0, $urandom, $urandom, 8'hA6, -1, 0, 1, 0);
        gap_first = 0;
        run_job("len0", 0, 0, $urandom, $urandom, 8'h5B, 8, 0, 0, 0);
        run_job("errpol", 3, 0, $urandom, $urandom, 8'h11, -1, 1, 0, 0);
        rand_wait = 1; rand_valid = 1;
        for (int j = 0; j < 6; j++)
            run_job($sformatf("rand%0d", j), $urandom_range(0, 6), 0, $urandom, $urandom,
                    8'($urandom), -1, 0, 0, 0);
        rand_wait = 0; rand_valid = 0;

        // Reset in the data phase of the second CRC_DR write.
        begin
            int st;
            prep(4, 0, 32'h1234_5678, 32'h8765_4321, 8'h3C, 0);
            pulse_start(4, 32'h1234_5678, 32'h8765_4321, 8'h3C, st);
            t = 0;
            while (dready_cnt < 2 && t < 500) begin @(negedge HCLK); #2; t++; end
            check("mid.reached_dr2", 32'(dready_cnt), 32'h2);
            @(negedge HCLK); #2;
            HRESETn = 0;
            #1;
            check("mid.htrans", 32'(HTRANS), 32'h0);
            check("mid.haddr", HADDR, 32'h0);
            check("mid.hwdata", HWDATA, 32'h0);
            check("mid.ctl", {27'h0, HWRITE, din_ready, busy, done, error}, 32'h0);
            check("mid.result", result, 32'h0);
            @(negedge HCLK);
            HRESETn = 1;
            busy_seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge HCLK); #2;
                if (HTRANS != 2'b00 || busy) busy_seen++;
            end
            check("mid.no_resume", 32'(busy_seen), 32'h0);
        end
        run_job("after_rst", 3, 0, $urandom, $urandom, 8'hF0, 14, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
